count_seq_checker: RTL and testbench
====================================

// Module: count_seq_checker
// PURPOSE
//  Receive-side checker for the free-running 8-bit counter stream produced by the
//  block counters. It samples count values on a valid strobe, acquires and locks
//  to the +1 sequence, flags sequence errors, and tolerates source resets (count
//  returning to 0). It sits on the consumer side of any counter output under test
//  and reports lock state and error statistics to the status block.
// PARAMETERS
//  WIDTH      8   data width of the sampled count; all compares are modulo 2**WIDTH
//  LOCK_COUNT 4   consecutive in-sequence samples required to lock (>=2)
//  ERR_LIMIT  3   consecutive errors while locked before lock is dropped (>=1)
//  CNT_W      16  width of the err_count and sample_count statistics counters
// PORTS
//  clock         in   1      single clock; all state updates on posedge
//  reset_n       in   1      asynchronous, active-low reset
//  in_valid      in   1      in_data is sampled on every clock edge where this is 1
//  in_data       in   WIDTH  count value from the source counter
//  clear         in   1      synchronous clear: statistics to 0, FSM to HUNT
//  locked        out  1      1 while FSM is in LOCKED
//  err_pulse     out  1      1-cycle pulse: a sequence error was detected
//  restart_pulse out  1      1-cycle pulse: source restart (0 received) while locked
//  expected      out  WIDTH  next value the checker expects
//  err_count     out  CNT_W  saturating count of sequence errors
//  sample_count  out  CNT_W  wrapping count of accepted samples
// BEHAVIOUR
//  - Reset (reset_n=0, async): state=HUNT, run=0, miss=0, every output 0.
//  - All outputs are registered. Pulses assert in the cycle after the sampling
//    edge and last exactly one cycle.
//  - "match": in_data == expected. expected is always (last accepted sample + 1)
//    mod 2**WIDTH, so 255 -> 0 is in sequence for WIDTH=8.
//  - Every accepted sample (in_valid=1, clear=0) increments sample_count (wraps)
//    and loads expected <= in_data + 1.
//  - FSM states: HUNT, ACQUIRE, LOCKED.
//    HUNT: on a sample, set run=1 and go to ACQUIRE. No errors are flagged.
//    ACQUIRE: on a match, run++; when run reaches LOCK_COUNT, go to LOCKED with
//      miss=0. On a mismatch, set run=1 and stay in ACQUIRE. No errors are flagged.
//    LOCKED, on a match: set miss=0.
//    LOCKED, on in_data==0 with no match: treat as a source restart. Pulse
//      restart_pulse, set miss=0, stay in LOCKED, no error.
//    LOCKED, on any other mismatch: pulse err_pulse, increment err_count
//      (saturates at all-ones), miss++. When miss reaches ERR_LIMIT, go to HUNT
//      (locked drops the next cycle) and set run=0.
//  - in_valid=0: no state, counter or expected change; pulses stay 0.
//  - clear=1 (takes priority over in_valid): err_count=0, sample_count=0,
//    run=0, miss=0, state=HUNT, expected=0. The concurrent sample is dropped and
//    no pulse is generated.
//  - reset_n asserted mid-sequence returns all state to the reset values
//    immediately. Lock is re-acquired only through HUNT/ACQUIRE.
//  - err_pulse and restart_pulse are never both 1.
// TESTING
//  1 Reset, then samples 10,11,12,13 on consecutive cycles -> locked=1 in the cycle
//    after 13, expected=14, sample_count=4, err_count=0.
//  2 Locked; feed 254,255,0,1 -> no err_pulse, no restart_pulse, expected=2.
//  3 Locked at expected=40; feed 0 -> restart_pulse=1 for 1 cycle, locked stays 1,
//    expected=1, err_count unchanged.
//  4 Locked at expected=20; feed 50,90,7 -> three err_pulses, err_count=3, locked=0
//    after the third; then 8,9,10,11 -> re-locked.
//  5 Locked; feed 5 then 6 -> err_count+1, miss=1; the match clears miss, so two
//    later errors do not drop lock. Separately, err_count preset near saturation
//    (CNT_W=4, 15 errors) plus one more -> err_count holds at 15.
//  6 clear=1 with in_valid=1 while locked -> next cycle locked=0, counters 0, no
//    pulse. reset_n pulsed low mid-ACQUIRE -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/count_seq_checker.sv
// -----------------------------------------------------------------------------
// count_seq_checker
//
// Receive-side checker for a free-running counter stream. Samples in_data on
// every clock edge where in_valid is high. It hunts for the +1 sequence and
// locks after LOCK_COUNT consecutive in-sequence samples. While locked it
// flags sequence errors. It treats a 0 that breaks the sequence as a source
// restart rather than an error. After ERR_LIMIT consecutive errors it drops
// lock and hunts again.
//
// Ports
//   clock         in   1      single clock, all updates on posedge
//   reset_n       in   1      asynchronous active-low reset
//   in_valid      in   1      sample strobe for in_data
//   in_data       in   WIDTH  count value from the source counter
//   clear         in   1      synchronous clear (statistics to 0, FSM to HUNT)
//   locked        out  1      high while the FSM is in LOCKED
//   err_pulse     out  1      one-cycle pulse per detected sequence error
//   restart_pulse out  1      one-cycle pulse per source restart while locked
//   expected      out  WIDTH  next value the checker expects
//   err_count     out  CNT_W  saturating sequence-error count
//   sample_count  out  CNT_W  wrapping accepted-sample count
//
// Every output is registered. The pulses appear in the cycle after the
// sampling edge.
// -----------------------------------------------------------------------------
module count_seq_checker #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_LIMIT  = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic             restart_pulse,
    output logic [WIDTH-1:0] expected,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sample_count
);

    // Run and miss counters only need to reach their thresholds.
    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(ERR_LIMIT + 1);

    localparam logic [RUN_W-1:0]  RUN_ZERO  = {RUN_W{1'b0}};
    localparam logic [RUN_W-1:0]  RUN_ONE   = {{(RUN_W-1){1'b0}}, 1'b1};
    localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0] MISS_ZERO = {MISS_W{1'b0}};
    localparam logic [MISS_W-1:0] MISS_ONE  = {{(MISS_W-1){1'b0}}, 1'b1};
    localparam logic [MISS_W-1:0] MISS_LIM  = MISS_W'(ERR_LIMIT);
    localparam logic [WIDTH-1:0]  DATA_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]  DATA_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    state_e              state_r;
    state_e              state_nxt_s;
    logic [RUN_W-1:0]    run_r;
    logic [RUN_W-1:0]    run_nxt_s;
    logic [RUN_W-1:0]    run_inc_s;
    logic [MISS_W-1:0]   miss_r;
    logic [MISS_W-1:0]   miss_nxt_s;
    logic [MISS_W-1:0]   miss_inc_s;

    logic                locked_r;
    logic                err_pulse_r;
    logic                restart_pulse_r;
    logic [WIDTH-1:0]    expected_r;
    logic [CNT_W-1:0]    err_count_r;
    logic [CNT_W-1:0]    sample_count_r;

    logic                match_s;
    logic                accept_s;
    logic                err_s;
    logic                restart_s;
    logic [WIDTH-1:0]    expected_nxt_s;
    logic [CNT_W-1:0]    err_count_nxt_s;
    logic [CNT_W-1:0]    sample_count_nxt_s;

    assign match_s    = (in_data == expected_r);
    assign accept_s   = in_valid & ~clear;
    assign run_inc_s  = run_r + RUN_ONE;
    assign miss_inc_s = miss_r + MISS_ONE;

    // Sequence FSM: next state, run/miss counters and pulse requests.
    always_comb begin
        state_nxt_s = state_r;
        run_nxt_s   = run_r;
        miss_nxt_s  = miss_r;
        err_s       = 1'b0;
        restart_s   = 1'b0;

        if (clear) begin
            // Clear wins over a concurrent sample, which is dropped.
            state_nxt_s = HUNT;
            run_nxt_s   = RUN_ZERO;
            miss_nxt_s  = MISS_ZERO;
        end else if (in_valid) begin
            case (state_r)
                HUNT: begin
                    // The first sample only seeds expected.
                    run_nxt_s   = RUN_ONE;
                    state_nxt_s = ACQUIRE;
                end
                ACQUIRE: begin
                    if (match_s) begin
                        if (run_inc_s == RUN_LOCK) begin
                            state_nxt_s = LOCKED;
                            miss_nxt_s  = MISS_ZERO;
                        end else begin
                            state_nxt_s = ACQUIRE;
                        end
                        run_nxt_s = run_inc_s;
                    end else begin
                        // A mismatch restarts the run from the new sample.
                        run_nxt_s = RUN_ONE;
                    end
                end
                LOCKED: begin
                    if (match_s) begin
                        miss_nxt_s = MISS_ZERO;
                    end else if (in_data == DATA_ZERO) begin
                        // Out-of-sequence zero means the source was reset.
                        restart_s  = 1'b1;
                        miss_nxt_s = MISS_ZERO;
                    end else begin
                        err_s      = 1'b1;
                        miss_nxt_s = miss_inc_s;
                        if (miss_inc_s == MISS_LIM) begin
                            state_nxt_s = HUNT;
                            run_nxt_s   = RUN_ZERO;
                        end else begin
                            state_nxt_s = LOCKED;
                        end
                    end
                end
                default: begin
                    state_nxt_s = HUNT;
                    run_nxt_s   = RUN_ZERO;
                    miss_nxt_s  = MISS_ZERO;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Datapath next values: expected value and statistics counters.
    always_comb begin
        expected_nxt_s     = expected_r;
        err_count_nxt_s    = err_count_r;
        sample_count_nxt_s = sample_count_r;

        if (clear) begin
            expected_nxt_s     = DATA_ZERO;
            err_count_nxt_s    = CNT_ZERO;
            sample_count_nxt_s = CNT_ZERO;
        end else if (accept_s) begin
            expected_nxt_s     = in_data + DATA_ONE;
            sample_count_nxt_s = sample_count_r + CNT_ONE;
            if (err_s && (err_count_r != CNT_MAX)) begin
                err_count_nxt_s = err_count_r + CNT_ONE;
            end else begin
                err_count_nxt_s = err_count_r;
            end
        end else begin
            expected_nxt_s = expected_r;
        end
    end

    // FSM state and internal run/miss counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= HUNT;
            run_r   <= RUN_ZERO;
            miss_r  <= MISS_ZERO;
        end else begin
            state_r <= state_nxt_s;
            run_r   <= run_nxt_s;
            miss_r  <= miss_nxt_s;
        end
    end

    // Registered outputs. locked follows the next state so it tracks state_r.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            locked_r        <= 1'b0;
            err_pulse_r     <= 1'b0;
            restart_pulse_r <= 1'b0;
            expected_r      <= DATA_ZERO;
            err_count_r     <= CNT_ZERO;
            sample_count_r  <= CNT_ZERO;
        end else begin
            locked_r        <= (state_nxt_s == LOCKED);
            err_pulse_r     <= err_s;
            restart_pulse_r <= restart_s;
            expected_r      <= expected_nxt_s;
            err_count_r     <= err_count_nxt_s;
            sample_count_r  <= sample_count_nxt_s;
        end
    end

    assign locked        = locked_r;
    assign err_pulse     = err_pulse_r;
    assign restart_pulse = restart_pulse_r;
    assign expected      = expected_r;
    assign err_count     = err_count_r;
    assign sample_count  = sample_count_r;

endmodule

// File: tb/tb_count_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_count_seq_checker
//
// Directed bench for count_seq_checker. Instance a uses the default
// parameters. Instance b uses CNT_W=4 and a large ERR_LIMIT, so err_count
// saturation and sample_count wrap can be reached while the instance stays
// locked.
// -----------------------------------------------------------------------------
module tb_count_seq_checker;

    logic        clock;
    logic        reset_n;

    logic        in_valid_a;
    logic [7:0]  in_data_a;
    logic        clear_a;
    logic        locked_a;
    logic        err_pulse_a;
    logic        restart_pulse_a;
    logic [7:0]  expected_a;
    logic [15:0] err_count_a;
    logic [15:0] sample_count_a;

    logic        in_valid_b;
    logic [7:0]  in_data_b;
    logic        clear_b;
    logic        locked_b;
    logic        err_pulse_b;
    logic        restart_pulse_b;
    logic [7:0]  expected_b;
    logic [3:0]  err_count_b;
    logic [3:0]  sample_count_b;

    int n_checks;
    int n_errors;

    count_seq_checker #(
        .WIDTH(8), .LOCK_COUNT(4), .ERR_LIMIT(3), .CNT_W(16)
    ) dut_a (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid_a), .in_data(in_data_a), .clear(clear_a),
        .locked(locked_a), .err_pulse(err_pulse_a),
        .restart_pulse(restart_pulse_a), .expected(expected_a),
        .err_count(err_count_a), .sample_count(sample_count_a)
    );

    count_seq_checker #(
        .WIDTH(8), .LOCK_COUNT(4), .ERR_LIMIT(20), .CNT_W(4)
    ) dut_b (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid_b), .in_data(in_data_b), .clear(clear_b),
        .locked(locked_b), .err_pulse(err_pulse_b),
        .restart_pulse(restart_pulse_b), .expected(expected_b),
        .err_count(err_count_b), .sample_count(sample_count_b)
    );

    // 10-unit clock; inputs change and outputs are read 1 unit after posedge.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic send_a(input logic [7:0] d);
        in_valid_a = 1'b1;
        in_data_a  = d;
        @(posedge clock);
        #1;
        in_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d);
        in_valid_b = 1'b1;
        in_data_b  = d;
        @(posedge clock);
        #1;
        in_valid_b = 1'b0;
    endtask

    task automatic idle;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_with_sample_a(input logic [7:0] d);
        clear_a    = 1'b1;
        in_valid_a = 1'b1;
        in_data_a  = d;
        @(posedge clock);
        #1;
        clear_a    = 1'b0;
        in_valid_a = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset_n    = 1'b1;
        in_valid_a = 1'b0;
        in_data_a  = 8'd0;
        clear_a    = 1'b0;
        in_valid_b = 1'b0;
        in_data_b  = 8'd0;
        clear_b    = 1'b0;

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        check("rst_locked",   32'(locked_a),        32'd0);
        check("rst_err",      32'(err_pulse_a),     32'd0);
        check("rst_restart",  32'(restart_pulse_a), 32'd0);
        check("rst_expected", 32'(expected_a),      32'd0);
        check("rst_errcnt",   32'(err_count_a),     32'd0);
        check("rst_smpcnt",   32'(sample_count_a),  32'd0);
        #9 reset_n = 1'b1;
        idle();

        // 1: acquire on 10..13
        send_a(8'd10);
        send_a(8'd11);
        send_a(8'd12);
        check("t1_not_yet_locked", 32'(locked_a), 32'd0);
        send_a(8'd13);
        check("t1_locked",   32'(locked_a),       32'd1);
        check("t1_expected", 32'(expected_a),     32'd14);
        check("t1_smpcnt",   32'(sample_count_a), 32'd4);
        check("t1_errcnt",   32'(err_count_a),    32'd0);
        idle();
        check("t1_idle_expected", 32'(expected_a),     32'd14);
        check("t1_idle_smpcnt",   32'(sample_count_a), 32'd4);
        check("t1_idle_locked",   32'(locked_a),       32'd1);

        // 6a: clear with a concurrent sample while locked
        clear_with_sample_a(8'd14);
        check("t6_clr_locked",   32'(locked_a),        32'd0);
        check("t6_clr_smpcnt",   32'(sample_count_a),  32'd0);
        check("t6_clr_errcnt",   32'(err_count_a),     32'd0);
        check("t6_clr_expected", 32'(expected_a),      32'd0);
        check("t6_clr_pulse",    32'(err_pulse_a | restart_pulse_a), 32'd0);

        // 2: wrap 254,255,0,1 while locked
        send_a(8'd250);
        send_a(8'd251);
        send_a(8'd252);
        send_a(8'd253);
        check("t2_locked", 32'(locked_a), 32'd1);
        send_a(8'd254);
        check("t2_err_254", 32'(err_pulse_a), 32'd0);
        send_a(8'd255);
        check("t2_err_255", 32'(err_pulse_a), 32'd0);
        send_a(8'd0);
        check("t2_err_0",     32'(err_pulse_a),     32'd0);
        check("t2_restart_0", 32'(restart_pulse_a), 32'd0);
        send_a(8'd1);
        check("t2_expected", 32'(expected_a),     32'd2);
        check("t2_errcnt",   32'(err_count_a),    32'd0);
        check("t2_smpcnt",   32'(sample_count_a), 32'd8);

        // 3: source restart at expected=40
        for (int v = 2; v < 40; v++) send_a(8'(v));
        check("t3_pre_expected", 32'(expected_a), 32'd40);
        send_a(8'd0);
        check("t3_restart",  32'(restart_pulse_a), 32'd1);
        check("t3_noerr",    32'(err_pulse_a),     32'd0);
        check("t3_locked",   32'(locked_a),        32'd1);
        check("t3_expected", 32'(expected_a),      32'd1);
        check("t3_errcnt",   32'(err_count_a),     32'd0);
        idle();
        check("t3_restart_gone", 32'(restart_pulse_a), 32'd0);

        // 4: three errors drop lock, then re-acquire on 8..11
        for (int v = 1; v < 20; v++) send_a(8'(v));
        check("t4_pre_expected", 32'(expected_a), 32'd20);
        send_a(8'd50);
        check("t4_err1",    32'(err_pulse_a), 32'd1);
        check("t4_locked1", 32'(locked_a),    32'd1);
        send_a(8'd90);
        check("t4_err2",    32'(err_pulse_a), 32'd1);
        check("t4_locked2", 32'(locked_a),    32'd1);
        send_a(8'd7);
        check("t4_err3",    32'(err_pulse_a), 32'd1);
        check("t4_errcnt",  32'(err_count_a), 32'd3);
        check("t4_dropped", 32'(locked_a),    32'd0);
        send_a(8'd8);
        check("t4_hunt_noerr", 32'(err_pulse_a), 32'd0);
        send_a(8'd9);
        send_a(8'd10);
        check("t4_relock_pending", 32'(locked_a), 32'd0);
        send_a(8'd11);
        check("t4_relocked", 32'(locked_a),    32'd1);
        check("t4_errcnt2",  32'(err_count_a), 32'd3);

        // 5: a match clears miss so two later errors keep lock
        send_a(8'd5);
        check("t5_err",    32'(err_pulse_a), 32'd1);
        check("t5_errcnt", 32'(err_count_a), 32'd4);
        send_a(8'd6);
        check("t5_match_noerr", 32'(err_pulse_a), 32'd0);
        send_a(8'd100);
        send_a(8'd200);
        check("t5_still_locked", 32'(locked_a),    32'd1);
        check("t5_errcnt2",      32'(err_count_a), 32'd6);

        // 5b: saturation on the 4-bit err_count, sample_count wraps
        send_b(8'd0);
        send_b(8'd1);
        send_b(8'd2);
        send_b(8'd3);
        check("t5b_locked", 32'(locked_b), 32'd1);
        for (int i = 0; i < 16; i++) begin
            send_b(8'(10 + 2 * i));
            if (i == 14) check("t5b_errcnt15", 32'(err_count_b), 32'd15);
        end
        check("t5b_errcnt_sat", 32'(err_count_b),    32'd15);
        check("t5b_err_pulse",  32'(err_pulse_b),    32'd1);
        check("t5b_locked2",    32'(locked_b),       32'd1);
        check("t5b_smpcnt",     32'(sample_count_b), 32'd4);

        // 6b: async reset mid-ACQUIRE
        clear_with_sample_a(8'd0);
        send_a(8'd30);
        send_a(8'd31);
        check("t6_acq_smpcnt", 32'(sample_count_a), 32'd2);
        reset_n = 1'b0;
        #1;
        check("t6_rst_smpcnt",   32'(sample_count_a), 32'd0);
        check("t6_rst_expected", 32'(expected_a),     32'd0);
        check("t6_rst_locked",   32'(locked_a),       32'd0);
        check("t6_rst_errcnt_b", 32'(err_count_b),    32'd0);
        check("t6_rst_locked_b", 32'(locked_b),       32'd0);
        #2 reset_n = 1'b1;
        idle();
        send_a(8'd40);
        send_a(8'd41);
        send_a(8'd42);
        check("t6_no_early_lock", 32'(locked_a), 32'd0);
        send_a(8'd43);
        check("t6_relock",  32'(locked_a),       32'd1);
        check("t6_smpcnt",  32'(sample_count_a), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
